// File: rtl/move_word_fifo.sv
// First-word-fall-through FIFO between the SPI word receiver and its consumer.
// A push happens only on the rising edge of the word_received strobe.
module move_word_fifo #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int DTR_FREE = 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [WIDTH-1:0]           word_data_received,
  input  logic                       word_received,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       buffer_dtr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [LW-1:0]    level_q, level_nxt;
  logic             wr_d;
  logic             dtr_q, dtr_nxt;
  logic             ovf_q, udf_q;
  logic             push, full, empty;
  logic             do_push, do_pop;
  logic             ovf_set, udf_set;

  assign push  = word_received & ~wr_d;
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  always_comb begin
    do_pop    = 1'b0;
    do_push   = 1'b0;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    level_nxt = level_q;
    if (clear) begin
      level_nxt = '0;
    end else begin
      // A valid pop frees the slot a same-cycle push needs when full.
      do_pop    = pop & ~empty;
      do_push   = push & (~full | do_pop);
      ovf_set   = push & full & ~do_pop;
      udf_set   = pop & empty;
      level_nxt = level_q + LW'(do_push) - LW'(do_pop);
    end
    dtr_nxt = ((DEPTH - int'(level_nxt)) >= DTR_FREE);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_d    <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      dtr_q   <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wr_d    <= word_received;
      level_q <= level_nxt;
      dtr_q   <= dtr_nxt;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        ovf_q  <= 1'b0;
        udf_q  <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        if (ovf_set) ovf_q  <= 1'b1;
        if (udf_set) udf_q  <= 1'b1;
      end
    end
  end

  // Storage has no reset; emptiness is tracked entirely by level and pointers.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= word_data_received;
  end

  assign word_out   = mem[rd_ptr];
  assign word_valid = ~empty;
  assign level      = level_q;
  assign buffer_dtr = dtr_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_move_word_fifo.sv
// Directed bench for move_word_fifo: a vector table of one-cycle steps plus
// hand-written reset sequences.
module tb_move_word_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  localparam logic [WIDTH-1:0] WA = 64'h1111_1111_1111_1111;
  localparam logic [WIDTH-1:0] WB = 64'h2222_2222_2222_2222;
  localparam logic [WIDTH-1:0] WC = 64'h3333_3333_3333_3333;
  localparam logic [WIDTH-1:0] WD = 64'h4444_4444_4444_4444;
  localparam logic [WIDTH-1:0] WE = 64'h5555_5555_5555_5555;
  localparam logic [WIDTH-1:0] WF = 64'h6666_6666_6666_6666;

  logic             CLK = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] word_data_received;
  logic             word_received;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic [LW-1:0]    level;
  logic             buffer_dtr;
  logic             overflow;
  logic             underflow;

  move_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DTR_FREE(1)) dut (
    .CLK                (CLK),
    .resetn             (resetn),
    .word_data_received (word_data_received),
    .word_received      (word_received),
    .pop                (pop),
    .clear              (clear),
    .word_out           (word_out),
    .word_valid         (word_valid),
    .level              (level),
    .buffer_dtr         (buffer_dtr),
    .overflow           (overflow),
    .underflow          (underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             wr;
    logic             pp;
    logic             clr;
    logic [WIDTH-1:0] data;
    int               lvl;
    logic             valid;
    logic [WIDTH-1:0] head;
    logic             dtr;
    logic             ovf;
    logic             udf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic pp, input logic clr, input logic [WIDTH-1:0] data,
                     input int lvl, input logic [WIDTH-1:0] head,
                     input logic dtr, input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.pp = pp; v.clr = clr; v.data = data;
    v.lvl = lvl; v.valid = (lvl != 0); v.head = head;
    v.dtr = dtr; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  task automatic check_state(input string tag, input int lvl, input logic [WIDTH-1:0] head,
                             input logic dtr, input logic ovf, input logic udf);
    chk({tag, "_level"}, WIDTH'(level), WIDTH'(lvl));
    chk({tag, "_valid"}, WIDTH'(word_valid), WIDTH'(lvl != 0));
    if (lvl != 0) chk({tag, "_word_out"}, word_out, head);
    chk({tag, "_dtr"}, WIDTH'(buffer_dtr), WIDTH'(dtr));
    chk({tag, "_ovf"}, WIDTH'(overflow), WIDTH'(ovf));
    chk({tag, "_udf"}, WIDTH'(underflow), WIDTH'(udf));
  endtask

  task automatic fill4(input int ovf);
    add(1,0,0,WA, 1,WA,1,ovf[0],0); add(0,0,0,'0, 1,WA,1,ovf[0],0);
    add(1,0,0,WB, 2,WA,1,ovf[0],0); add(0,0,0,'0, 2,WA,1,ovf[0],0);
    add(1,0,0,WC, 3,WA,1,ovf[0],0); add(0,0,0,'0, 3,WA,1,ovf[0],0);
    add(1,0,0,WD, 4,WA,0,ovf[0],0); add(0,0,0,'0, 4,WA,0,ovf[0],0);
  endtask

  initial begin
    resetn = 1'b0; word_received = 1'b0; pop = 1'b0; clear = 1'b0;
    word_data_received = '0;

    // Three pushes, then three pops in order.
    add(1,0,0,WA, 1,WA,1,0,0); add(0,0,0,'0, 1,WA,1,0,0);
    add(1,0,0,WB, 2,WA,1,0,0); add(0,0,0,'0, 2,WA,1,0,0);
    add(1,0,0,WC, 3,WA,1,0,0);
    add(0,1,0,'0, 2,WB,1,0,0); add(0,1,0,'0, 1,WC,1,0,0); add(0,1,0,'0, 0,'0,1,0,0);
    // Fill to 4, fifth push overflows; head unchanged.
    fill4(0);
    add(1,0,0,WE, 4,WA,0,1,0); add(0,0,0,'0, 4,WA,0,1,0);
    add(0,0,1,'0, 0,'0,1,0,0);
    // Full with simultaneous push and pop.
    fill4(0);
    add(1,1,0,WE, 4,WB,0,0,0);
    add(0,1,0,'0, 3,WC,1,0,0); add(0,1,0,'0, 2,WD,1,0,0);
    add(0,1,0,'0, 1,WE,1,0,0); add(0,1,0,'0, 0,'0,1,0,0);
    // Strobe held for 10 cycles pushes once.
    for (int i = 0; i < 10; i++) add(1,0,0,WF, 1,WF,1,0,0);
    add(0,0,0,'0, 1,WF,1,0,0); add(0,1,0,'0, 0,'0,1,0,0);
    // Underflow, then clear wins over a push.
    add(0,1,0,'0, 0,'0,1,0,1);
    add(1,0,1,WA, 0,'0,1,0,0); add(0,0,0,'0, 0,'0,1,0,0);
    // Push and pop while empty: word stored, pop flagged.
    add(1,1,0,WB, 1,WB,1,0,1); add(0,0,0,'0, 1,WB,1,0,1);
    // Strobe held across clear does not push again.
    add(0,0,1,'0, 0,'0,1,0,0);
    add(1,0,0,WC, 1,WC,1,0,0); add(1,0,1,WC, 0,'0,1,0,0);
    add(1,0,0,WC, 0,'0,1,0,0); add(0,0,0,'0, 0,'0,1,0,0);

    #12;
    check_state("reset", 0, '0, 1, 0, 0);
    @(negedge CLK);
    resetn = 1'b1;

    @(posedge CLK); #1;
    foreach (vecs[i]) begin
      word_received      = vecs[i].wr;
      pop                = vecs[i].pp;
      clear              = vecs[i].clr;
      word_data_received = vecs[i].data;
      @(posedge CLK); #1;
      check_state($sformatf("v%0d", i), vecs[i].lvl, vecs[i].head,
                  vecs[i].dtr, vecs[i].ovf, vecs[i].udf);
    end

    // Reach level 2, then an async reset pulse between edges.
    word_received = 1'b1; pop = 1'b0; clear = 1'b0; word_data_received = WD;
    @(posedge CLK); #1;
    word_received = 1'b0;
    @(posedge CLK); #1;
    word_received = 1'b1; word_data_received = WE;
    @(posedge CLK); #1;
    word_received = 1'b0;
    @(posedge CLK); #1;
    check_state("pre_rst", 2, WD, 1, 0, 0);
    #3 resetn = 1'b0;
    #2 check_state("mid_rst", 0, '0, 1, 0, 0);
    // Release reset with the strobe high: counts as a fresh rising strobe.
    word_received = 1'b1; word_data_received = WF;
    #2 resetn = 1'b1;
    @(posedge CLK); #1;
    check_state("post_rst", 1, WF, 1, 0, 0);
    @(posedge CLK); #1;
    check_state("post_rst_hold", 1, WF, 1, 0, 0);
    word_received = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
